// File: rtl/stream_cipher_pkg.sv
// Shared state encodings, seed constant and keystream step for the stream cipher engine.
package stream_cipher_pkg;

    typedef enum logic [1:0] {I_IDLE, I_CRYPT, I_ACK} engine_in_state_t;
    typedef enum logic [1:0] {O_IDLE, O_PRESENT, O_RELEASE} engine_out_state_t;

    localparam logic [31:0] SEED_FALLBACK = 32'hA5A5A5A5;

    function automatic logic [31:0] xorshift32(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

endpackage

// File: rtl/stream_cipher_engine_beat_fifo.sv
// Beat FIFO: power-of-two depth, pointers wrap naturally, contents not reset.
module beat_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_nrst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != (AW+1)'(DEPTH)) || w_do_pop);

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/stream_cipher_engine.sv
// Multi-lane XOR stream cipher: key loading, xorshift32 keystream, buffered 4-phase output.
module stream_cipher_engine
    import stream_cipher_pkg::*;
#(
    parameter int unsigned LANES     = 1,
    parameter int unsigned KEY_BYTES = 16,
    parameter int unsigned OUT_DEPTH = 4
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [8*LANES-1:0] in_byte,
    input  logic               in_is_key,
    input  logic               in_reset_hash,
    input  logic               in_req,
    output logic               in_ack,
    output logic               out_ready,
    input  logic               out_ack,
    output logic [8*LANES-1:0] out_byte,
    output logic               busy
);

    localparam int unsigned BW = 8 * LANES;
    localparam int unsigned KW = 8 * KEY_BYTES;
    localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned CW = $clog2(OUT_DEPTH) + 1;

    engine_in_state_t  r_in_state, w_in_next;
    engine_out_state_t r_out_state, w_out_next;

    logic [KW-1:0] r_key;
    logic [KW-1:0] w_key_shifted;
    logic [31:0]   r_s;
    logic [31:0]   w_s_step;
    logic [BW-1:0] r_beat;
    logic [BW-1:0] w_beat_xored;
    logic [LW-1:0] r_lane;
    logic          r_out_ready;
    logic [BW-1:0] r_out_byte;

    logic          w_key_load;
    logic          w_data_accept;
    logic          w_last_lane;
    logic          w_present;
    logic          w_fifo_push;
    logic          w_fifo_pop;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [BW-1:0] w_fifo_head;
    logic [CW-1:0] w_fifo_count;

    function automatic logic [31:0] fold_seed(input logic [KW-1:0] key);
        logic [31:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < KEY_BYTES / 4; i++) acc ^= key[32*i +: 32];
        return (acc == '0) ? SEED_FALLBACK : acc;
    endfunction

    // Lanes are inserted reversed so lane 0 sits in the oldest (most significant) byte slot.
    always_comb begin
        w_key_shifted = r_key << BW;
        for (int unsigned l = 0; l < LANES; l++)
            w_key_shifted[8*(LANES-1-l) +: 8] = in_byte[8*l +: 8];
    end

    assign w_s_step    = xorshift32(r_s);
    assign w_last_lane = (r_lane == LW'(LANES - 1));

    always_comb begin
        w_beat_xored = r_beat;
        for (int unsigned l = 0; l < LANES; l++)
            if (r_lane == LW'(l)) w_beat_xored[8*l +: 8] = r_beat[8*l +: 8] ^ w_s_step[7:0];
    end

    always_comb begin
        w_in_next     = r_in_state;
        w_key_load    = 1'b0;
        w_data_accept = 1'b0;
        w_fifo_push   = 1'b0;
        case (r_in_state)
            I_IDLE: begin
                if (in_req) begin
                    if (in_is_key) begin
                        w_key_load = 1'b1;
                        w_in_next  = I_ACK;
                    end else if (!w_fifo_full) begin
                        w_data_accept = 1'b1;
                        w_in_next     = I_CRYPT;
                    end
                end
            end
            I_CRYPT: begin
                if (w_last_lane) begin
                    w_fifo_push = 1'b1;
                    w_in_next   = I_ACK;
                end
            end
            I_ACK:   if (!in_req) w_in_next = I_IDLE;
            default: w_in_next = I_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) r_in_state <= I_IDLE;
        else       r_in_state <= w_in_next;
    end

    // A key beat always reseeds from the new key, which also covers a simultaneous reset_hash.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_key  <= '0;
            r_s    <= SEED_FALLBACK;
            r_beat <= '0;
            r_lane <= '0;
        end else if (w_key_load) begin
            r_key <= w_key_shifted;
            r_s   <= fold_seed(w_key_shifted);
        end else if (w_data_accept) begin
            r_beat <= in_byte;
            r_lane <= '0;
            if (in_reset_hash) r_s <= fold_seed(r_key);
        end else if (r_in_state == I_CRYPT) begin
            r_s    <= w_s_step;
            r_beat <= w_beat_xored;
            r_lane <= r_lane + 1'b1;
        end
    end

    beat_fifo #(
        .WIDTH (BW),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_nrst  (nrst),
        .i_push  (w_fifo_push),
        .i_pop   (w_fifo_pop),
        .i_wdata (w_beat_xored),
        .o_head  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    always_comb begin
        w_out_next = r_out_state;
        w_present  = 1'b0;
        w_fifo_pop = 1'b0;
        case (r_out_state)
            O_IDLE: begin
                if (!w_fifo_empty) begin
                    w_present  = 1'b1;
                    w_out_next = O_PRESENT;
                end
            end
            O_PRESENT: begin
                if (out_ack) begin
                    w_fifo_pop = 1'b1;
                    w_out_next = O_RELEASE;
                end
            end
            O_RELEASE: if (!out_ack) w_out_next = O_IDLE;
            default:   w_out_next = O_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_out_state <= O_IDLE;
            r_out_ready <= 1'b0;
            r_out_byte  <= '0;
        end else begin
            r_out_state <= w_out_next;
            if (w_present) begin
                r_out_byte  <= w_fifo_head;
                r_out_ready <= 1'b1;
            end else if (w_fifo_pop) begin
                r_out_ready <= 1'b0;
            end
        end
    end

    assign in_ack    = (r_in_state == I_ACK);
    assign out_ready = r_out_ready;
    assign out_byte  = r_out_byte;
    assign busy      = (r_in_state == I_CRYPT) || (w_fifo_count != '0);

endmodule

// File: tb/tb_stream_cipher_engine.sv
// Directed bench for stream_cipher_engine: one LANES=1 instance and one LANES=4 instance.
module tb_stream_cipher_engine;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  a_in_byte = '0;
    logic        a_is_key = 1'b0, a_rh = 1'b0, a_req = 1'b0, a_oack = 1'b0;
    logic        a_ack, a_ordy, a_busy;
    logic [7:0]  a_obyte;

    logic [31:0] b_in_byte = '0;
    logic        b_is_key = 1'b0, b_rh = 1'b0, b_req = 1'b0, b_oack = 1'b0;
    logic        b_ack, b_ordy, b_busy;
    logic [31:0] b_obyte;

    int unsigned errors = 0;
    int unsigned checks = 0;

    stream_cipher_engine #(.LANES(1), .KEY_BYTES(16), .OUT_DEPTH(4)) dut1 (
        .clk(clk), .nrst(nrst), .in_byte(a_in_byte), .in_is_key(a_is_key),
        .in_reset_hash(a_rh), .in_req(a_req), .in_ack(a_ack), .out_ready(a_ordy),
        .out_ack(a_oack), .out_byte(a_obyte), .busy(a_busy)
    );

    stream_cipher_engine #(.LANES(4), .KEY_BYTES(16), .OUT_DEPTH(4)) dut4 (
        .clk(clk), .nrst(nrst), .in_byte(b_in_byte), .in_is_key(b_is_key),
        .in_reset_hash(b_rh), .in_req(b_req), .in_ack(b_ack), .out_ready(b_ordy),
        .out_ack(b_oack), .out_byte(b_obyte), .busy(b_busy)
    );

    function automatic logic [31:0] xs(input logic [31:0] v);
        logic [31:0] t;
        t = v ^ (v << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send1(input logic [7:0] d, input logic k, input logic rh);
        int unsigned n;
        @(negedge clk);
        a_in_byte = d; a_is_key = k; a_rh = rh; a_req = 1'b1;
        n = 0;
        while (a_ack !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("in_ack_rise", {31'd0, a_ack}, 32'd1);
        a_req = 1'b0;
        n = 0;
        while (a_ack !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        chk("in_ack_fall", {31'd0, a_ack}, 32'd0);
    endtask

    task automatic recv1(output logic [7:0] d);
        int unsigned n;
        n = 0;
        while (a_ordy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("out_ready_rise", {31'd0, a_ordy}, 32'd1);
        d = a_obyte;
        a_oack = 1'b1;
        n = 0;
        while (a_ordy !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        chk("out_ready_fall", {31'd0, a_ordy}, 32'd0);
        a_oack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  k0, k1, k2, o;
        logic [31:0] s, e;
        int unsigned n;

        // Reset and idle outputs
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ack", {31'd0, a_ack}, 32'd0);
        chk("rst_out_ready", {31'd0, a_ordy}, 32'd0);
        chk("rst_out_byte", {24'd0, a_obyte}, 32'd0);
        chk("rst_busy", {31'd0, a_busy}, 32'd0);
        chk("rst4_out_byte", b_obyte, 32'd0);

        // Zero key: keystream bytes appear directly
        send1(8'h00, 1'b0, 1'b1);
        send1(8'h00, 1'b0, 1'b0);
        send1(8'h00, 1'b0, 1'b0);
        chk("busy_fifo_nonempty", {31'd0, a_busy}, 32'd1);
        recv1(k0); recv1(k1); recv1(k2);
        s = xs(32'hA5A5A5A5);
        chk("k0", {24'd0, k0}, 32'h8D);
        s = xs(s);
        chk("k1", {24'd0, k1}, {24'd0, s[7:0]});
        s = xs(s);
        chk("k2", {24'd0, k2}, {24'd0, s[7:0]});

        // Decrypt round trip
        send1(k0, 1'b0, 1'b1);
        send1(k1, 1'b0, 1'b0);
        send1(k2, 1'b0, 1'b0);
        recv1(o); chk("dec0", {24'd0, o}, 32'd0);
        recv1(o); chk("dec1", {24'd0, o}, 32'd0);
        recv1(o); chk("dec2", {24'd0, o}, 32'd0);

        // Key 0x01..0x10 folds to seed 0x10; xorshift32(0x10)[7:0]=0x31
        for (int i = 1; i <= 16; i++) send1(8'(i), 1'b1, 1'b0);
        send1(8'h5A, 1'b0, 1'b1); recv1(o); chk("key_enc_a", {24'd0, o}, 32'h6B);
        send1(8'h5A, 1'b0, 1'b1); recv1(o); chk("key_enc_b", {24'd0, o}, 32'h6B);
        // Key 0x02..0x10,0x80 folds to 0x1081; xorshift32 low byte 0xA9
        send1(8'h80, 1'b1, 1'b0);
        send1(8'h5A, 1'b0, 1'b1); recv1(o); chk("key2_enc", {24'd0, o}, 32'hF3);

        // Backpressure with a full FIFO
        for (int i = 0; i < 4; i++) send1(8'(i), 1'b0, 1'b0);
        send1(8'h33, 1'b1, 1'b0);
        @(negedge clk);
        a_in_byte = 8'h44; a_is_key = 1'b0; a_rh = 1'b0; a_req = 1'b1;
        repeat (10) @(negedge clk);
        chk("full_stall_ack", {31'd0, a_ack}, 32'd0);
        recv1(o);
        n = 0;
        while (a_ack !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("after_pop_accept", {31'd0, a_ack}, 32'd1);
        a_req = 1'b0;
        n = 0;
        while (a_ack !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        for (int i = 0; i < 4; i++) recv1(o);
        repeat (3) @(negedge clk);
        chk("drained_busy", {31'd0, a_busy}, 32'd0);

        // Held in_req: single beat only
        a_in_byte = 8'h12; a_req = 1'b1;
        n = 0;
        while (a_ack !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        chk("held_req_ack", {31'd0, a_ack}, 32'd1);
        a_req = 1'b0;
        n = 0;
        while (a_ack !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        recv1(o);
        repeat (5) @(negedge clk);
        chk("no_second_beat", {31'd0, a_ordy}, 32'd0);

        // Held out_ack: next beat waits for release
        send1(8'h01, 1'b0, 1'b0);
        send1(8'h02, 1'b0, 1'b0);
        n = 0;
        while (a_ordy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        a_oack = 1'b1;
        n = 0;
        while (a_ordy !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        chk("held_oack_no_present", {31'd0, a_ordy}, 32'd0);
        a_oack = 1'b0;
        n = 0;
        while (a_ordy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("present_after_release", {31'd0, a_ordy}, 32'd1);
        recv1(o);

        // LANES=4 latency and lane order (zero key, seed from reset)
        @(negedge clk);
        b_in_byte = 32'h0; b_req = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (b_ack !== 1'b1 && n < 20);
        chk("l4_ack_latency", n, 32'd5);
        @(negedge clk);
        b_req = 1'b0;
        n = 0;
        while (b_ordy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        s = 32'hA5A5A5A5;
        e = '0;
        for (int l = 0; l < 4; l++) begin s = xs(s); e[8*l +: 8] = s[7:0]; end
        chk("l4_lane0", {24'd0, b_obyte[7:0]}, 32'h8D);
        chk("l4_lanes", b_obyte, e);
        b_oack = 1'b1;
        n = 0;
        while (b_ordy !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        b_oack = 1'b0;
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of encryption
        b_in_byte = 32'h11223344; b_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("l4_busy_crypt", {31'd0, b_busy}, 32'd1);
        #2 nrst = 1'b0;
        #1;
        chk("arst_busy", {31'd0, b_busy}, 32'd0);
        chk("arst_in_ack", {31'd0, b_ack}, 32'd0);
        chk("arst_out_ready", {31'd0, b_ordy}, 32'd0);
        chk("arst_out_byte", b_obyte, 32'd0);
        chk("arst_a_out_byte", {24'd0, a_obyte}, 32'd0);
        b_req = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_cipher_engine.md
Name: stream_cipher_engine

Overview:
Parametrised successor to the byte-serial stream cipher datapath. It accepts LANES bytes per 4-phase input handshake and loads them either into a KEY_BYTES-wide key register or through a 32-bit xorshift keystream generator (XOR encrypt/decrypt). Encrypted beats are buffered in an OUT_DEPTH-entry FIFO and delivered on a 4-phase output handshake. It sits between the chip pins and the external reader/consumer.

Parameters:
LANES, 1, bytes per beat (1..8)
KEY_BYTES, 16, key length in bytes (multiple of 4, >= LANES)
OUT_DEPTH, 4, output FIFO depth in beats (power of 2, >= 2)

Ports:
clk  in  1  clock
nrst  in  1  asynchronous active-low reset
in_byte  in  8*LANES  input beat; lane 0 = [7:0] = first byte in stream order
in_is_key  in  1  beat is key material
in_reset_hash  in  1  reseed keystream from current key
in_req  in  1  input 4-phase request
in_ack  out  1  input 4-phase acknowledge
out_ready  out  1  output beat valid (output 4-phase request)
out_ack  in  1  consumer acknowledge
out_byte  out  8*LANES  output beat; lane order as in_byte
busy  out  1  encryption in progress or FIFO non-empty

Behaviour:
- One clock; reset is asynchronous and active-low. Reset clears all state: in_ack=0, out_ready=0, out_byte=0, busy=0, key=0, FIFO empty, S=32'hA5A5A5A5.
- Input FSM states: I_IDLE, I_CRYPT, I_ACK.
- I_IDLE, in_req=1:
  - Key beat: shift the key register left by 8*LANES and insert in_byte, so the lane 0 byte ends up oldest. Reseed S, then go to I_ACK.
  - Data beat: if FIFO count plus in-flight beats < OUT_DEPTH, latch the beat, set lane index 0, go to I_CRYPT. Otherwise stay in I_IDLE with in_ack low (backpressure).
- in_reset_hash is sampled with the beat. It reseeds S before the beat is processed. A key beat with reset_hash reseeds once, from the new key.
- Seed: XOR-fold the key into 32-bit words. If the result is 0, substitute 32'hA5A5A5A5.
- I_CRYPT: one lane per cycle.
  - Update S with xorshift32: x^=x<<13; x^=x>>17; x^=x<<5.
  - Lane byte ^= new S[7:0].
  - After lane LANES-1, push the beat to the FIFO and go to I_ACK. Data latency is LANES cycles from acceptance to FIFO push.
- I_ACK: in_ack=1 until in_req is sampled 0. Then in_ack=0 and return to I_IDLE.
- Output FSM states: O_IDLE, O_PRESENT, O_RELEASE.
  - O_IDLE, FIFO non-empty: drive out_byte=head, set out_ready=1 (registered, 1 cycle after push at earliest), go to O_PRESENT.
  - O_PRESENT, out_ack=1: out_ready=0, pop head, go to O_RELEASE.
  - O_RELEASE: wait for out_ack=0, then go to O_IDLE.
  - out_byte holds its value until the next presentation.
- Simultaneous push and pop in one cycle: count stays unchanged; pointers wrap modulo OUT_DEPTH.
- FIFO full: input data beats stall in I_IDLE. Key and reset-only beats are still accepted.
- Key beats never enter the FIFO.
- Reset mid-operation: an in-flight beat is discarded and the FIFO contents are lost.

Decomposition:
- Package stream_cipher_pkg holds:
  - typedefs engine_in_state_t {I_IDLE, I_CRYPT, I_ACK} and engine_out_state_t {O_IDLE, O_PRESENT, O_RELEASE};
  - constant SEED_FALLBACK = 32'hA5A5A5A5;
  - function xorshift32.
- Sub-module: beat_fifo (parametrised WIDTH and DEPTH, push/pop/full/empty/count).

Test Plan:
- Reset, then idle: in_ack=0, out_ready=0, out_byte=0, busy=0. Assert nrst low mid-I_CRYPT: all outputs return to 0 asynchronously.
- LANES=1, all-zero key. Send reset_hash plus data 0x00 ×3 and capture outputs k0,k1,k2 (k0 = xorshift32(32'hA5A5A5A5)[7:0]). Then reset_hash and send k0,k1,k2 -> outputs 0x00,0x00,0x00.
- Load a 16-byte key 0x01..0x10. Send reset_hash with data D=0x5A, then reset_hash with D=0x5A again -> both outputs are identical. A different key gives a different output.
- OUT_DEPTH=4, consumer never acks: 4 data beats are accepted and the 5th holds in_ack=0. A key beat is still acked. One out_ack cycle frees a slot and the 5th beat is then accepted.
- LANES=4: the beat 0x00000000 takes 4 cycles from acceptance to push. The output lanes equal 4 successive keystream bytes, lane 0 first.
- Protocol: hold in_req high for 10 cycles -> in_ack stays 1 with no second beat accepted. Keep out_ack high after the pop -> the next beat is not presented until out_ack=0.
